w_mem_load_ctrl: RTL and testbench
==================================

W_MEM_LOAD_CTRL -- requirements
Module: w_mem_load_ctrl

Interface
REQ-001 SHALL have parameter WEIGHT_DATA_WIDTH, default 8, meaning bits per weight.
REQ-002 SHALL have parameter N_DIM_ARRAY, default 4, meaning weights per write word (word = 32 bits).
REQ-003 SHALL have parameter ADDR_W, default 12, meaning weight-memory word address width (4096 words).
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle request to begin a load; sampled only in IDLE.
REQ-007 clear  input  1  synchronous soft abort; returns the block to IDLE.
REQ-008 mode  input  3  1 = CNN target port; any other value = FC target port; latched at start.
REQ-009 base_addr  input  ADDR_W  first write address; latched at start.
REQ-010 num_words  input  ADDR_W+1  number of words to load, 0..4096; latched at start.
REQ-011 in_data  input  32  weight word stream, 4 weights packed MSB-first.
REQ-012 in_valid / in_ready  input / output  1 each  stream handshake; transfer occurs when both are 1.
REQ-013 wr_enable_cnn, wr_addr_cnn, wr_data_cnn  output  1, ADDR_W, 32  CNN write port of the weight memory.
REQ-014 wr_enable_fc, wr_addr_fc, wr_data_fc  output  1, ADDR_W, 32  FC write port of the weight memory.
REQ-015 busy, done, err  output  1 each  load in progress; one-cycle completion pulse; range error.

Function
REQ-016 SHALL implement an FSM with states IDLE, LOAD and DONE.
REQ-017 IDLE->LOAD SHALL occur on start=1 when num_words>0; on start=1 with num_words=0 the FSM SHALL go IDLE->DONE and issue no write.
REQ-018 in_ready SHALL be 1 only in LOAD, combinationally from state.
REQ-019 Each handshake k (k=0..num_words-1) at cycle t SHALL produce exactly one write at t+1, from registered outputs: addr = (base_addr+k) mod 2^ADDR_W, data = in_data.
REQ-020 The write SHALL use the CNN port when the latched mode=1 and the FC port otherwise; the unused port SHALL have enable, addr and data at 0.
REQ-021 The handshake k=num_words-1 SHALL move LOAD->DONE; DONE SHALL last one cycle and then go to IDLE.
REQ-022 done SHALL be 1 exactly in the DONE cycle, which coincides with the last write.
REQ-023 busy SHALL be 1 in LOAD and DONE, and 0 in IDLE.
REQ-024 start SHALL be ignored outside IDLE; in_valid SHALL be ignored outside LOAD.
REQ-025 in_valid=0 in LOAD SHALL stall the block with no write and no address advance.
REQ-026 clear=1 SHALL force IDLE on the next edge with no done pulse, and SHALL zero both write enables; clear has priority over start and over a handshake in the same cycle.

Reset
REQ-027 While reset=0: state=IDLE, all outputs 0, internal counter and latched configuration 0.
REQ-028 Reset asserted mid-load SHALL abandon the load, with no further writes and no done pulse.

Configuration
REQ-029 With W_LOAD_RANGE_CHECK_EN defined, start with base_addr+num_words>4096 SHALL go IDLE->DONE with no writes and set err=1.
REQ-030 With W_LOAD_RANGE_CHECK_EN defined, err SHALL be sticky until the next accepted start, clear, or reset.
REQ-031 Without W_LOAD_RANGE_CHECK_EN, err SHALL be tied to 0 and addresses SHALL wrap modulo 2^ADDR_W.

Structure
REQ-032 MODE_CNN=1, WEIGHT_MEMORY_ADDR_SIZE=12, WEIGHT_DATA_WIDTH=8, N_DIM_ARRAY=4 and the FSM state typedef SHALL reside in the shared parameters package.
REQ-033 The block SHALL contain no sub-module; FSM, counter and output registers SHALL be flat in the one module.

Verification
REQ-034 mode=1, base=0x010, num=4, continuous valid -> CNN writes at 0x010..0x013 on consecutive cycles; done coincides with write 0x013; FC enable stays 0.
REQ-035 mode=2, base=0x100, num=3, valid low for 2 cycles after the first transfer -> FC writes 0x100, 0x101, 0x102 with a 2-cycle gap; data matches the input order.
REQ-036 num=0 start -> done one cycle later, busy high for that one cycle, zero writes.
REQ-037 base=0xFFE, num=4 -> without the macro, addresses 0xFFE, 0xFFF, 0x000, 0x001; with the macro, err=1, done pulse, zero writes.
REQ-038 clear after 2 of 5 transfers -> exactly 2 writes, no done, busy=0 next cycle; a following start loads normally.
REQ-039 reset pulsed low mid-load -> all outputs 0 immediately; in_ready=0 until the next start.

Source files
------------

// File: rtl/w_mem_load_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// w_mem_load_ctrl_pkg
// Shared parameters for the weight-memory load controller: target-mode code,
// weight-memory geometry, and the load FSM state type.
// Optional feature macro (used by w_mem_load_ctrl): W_LOAD_RANGE_CHECK_EN
// -----------------------------------------------------------------------------
package w_mem_load_ctrl_pkg;

    localparam int MODE_CNN                = 1;
    localparam int WEIGHT_MEMORY_ADDR_SIZE = 12;
    localparam int WEIGHT_DATA_WIDTH       = 8;
    localparam int N_DIM_ARRAY             = 4;
    localparam int WEIGHT_WORD_W           = WEIGHT_DATA_WIDTH * N_DIM_ARRAY;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } load_state_t;

endpackage

// File: rtl/w_mem_load_ctrl_if.sv
// -----------------------------------------------------------------------------
// w_mem_load_ctrl_if
// Weight word stream feeding the load controller.
//   in_data  : one packed weight word (weights MSB-first)
//   in_valid : source has a word available
//   in_ready : controller accepts a word; transfer when both are high
// Modports: master = stream source, slave = load controller.
// -----------------------------------------------------------------------------
interface w_mem_load_ctrl_if #(
    parameter int DATA_W = w_mem_load_ctrl_pkg::WEIGHT_WORD_W
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready
    );
endinterface

// File: rtl/w_mem_load_ctrl.sv
// -----------------------------------------------------------------------------
// w_mem_load_ctrl
// Copies num_words weight words from a valid/ready stream into the weight
// memory, starting at base_addr, through either the CNN or the FC write port
// (chosen by mode at start). One write per accepted word, one cycle after the
// handshake; done pulses together with the last write.
//
// Ports
//   clk, reset (async, active-low)
//   start, clear, mode[2:0], base_addr[ADDR_W-1:0], num_words[ADDR_W:0]
//   stream        : weight word stream (slave modport: in_data/in_valid/in_ready)
//   wr_enable_cnn, wr_addr_cnn, wr_data_cnn : CNN write port
//   wr_enable_fc,  wr_addr_fc,  wr_data_fc  : FC write port
//   busy, done, err
//
// Optional feature: define W_LOAD_RANGE_CHECK_EN to reject loads whose
// address range runs past the top of memory (err set, no writes). Without it
// addresses wrap and err is tied low.
// -----------------------------------------------------------------------------
module w_mem_load_ctrl #(
    parameter int WEIGHT_DATA_WIDTH = w_mem_load_ctrl_pkg::WEIGHT_DATA_WIDTH,
    parameter int N_DIM_ARRAY       = w_mem_load_ctrl_pkg::N_DIM_ARRAY,
    parameter int ADDR_W            = w_mem_load_ctrl_pkg::WEIGHT_MEMORY_ADDR_SIZE
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 clear,
    input  logic [2:0]           mode,
    input  logic [ADDR_W-1:0]    base_addr,
    input  logic [ADDR_W:0]      num_words,
    w_mem_load_ctrl_if.slave     stream,
    output logic                 wr_enable_cnn,
    output logic [ADDR_W-1:0]    wr_addr_cnn,
    output logic [WEIGHT_DATA_WIDTH*N_DIM_ARRAY-1:0] wr_data_cnn,
    output logic                 wr_enable_fc,
    output logic [ADDR_W-1:0]    wr_addr_fc,
    output logic [WEIGHT_DATA_WIDTH*N_DIM_ARRAY-1:0] wr_data_fc,
    output logic                 busy,
    output logic                 done,
    output logic                 err
);
    import w_mem_load_ctrl_pkg::*;

    localparam int WORD_W = WEIGHT_DATA_WIDTH * N_DIM_ARRAY;

    load_state_t       state_reg;
    logic [ADDR_W-1:0] addr_reg;   // next write address
    logic [ADDR_W:0]   num_reg;    // latched word count
    logic [ADDR_W:0]   cnt_reg;    // words written so far
    logic              cnn_reg;    // latched target port select
    logic              last_xfer;

    assign last_xfer       = (cnt_reg == (num_reg - {{ADDR_W{1'b0}}, 1'b1}));
    assign stream.in_ready = (state_reg == LOAD);
    assign busy            = (state_reg != IDLE);

`ifdef W_LOAD_RANGE_CHECK_EN
    localparam logic [ADDR_W+1:0] ADDR_SPAN = (ADDR_W+2)'(1) << ADDR_W;

    logic              err_reg;
    logic [ADDR_W+1:0] end_addr;
    logic              out_of_range;

    // Zero-extend both operands so the sum cannot overflow before comparing.
    assign end_addr     = {2'b00, base_addr} + {1'b0, num_words};
    assign out_of_range = (end_addr > ADDR_SPAN);
    assign err          = err_reg;
`else
    assign err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg     <= IDLE;
            addr_reg      <= '0;
            num_reg       <= '0;
            cnt_reg       <= '0;
            cnn_reg       <= 1'b0;
            wr_enable_cnn <= 1'b0;
            wr_addr_cnn   <= '0;
            wr_data_cnn   <= '0;
            wr_enable_fc  <= 1'b0;
            wr_addr_fc    <= '0;
            wr_data_fc    <= '0;
            done          <= 1'b0;
`ifdef W_LOAD_RANGE_CHECK_EN
            err_reg       <= 1'b0;
`endif
        end else begin
            // Write ports and done are single-cycle; idle at zero by default.
            wr_enable_cnn <= 1'b0;
            wr_addr_cnn   <= '0;
            wr_data_cnn   <= '0;
            wr_enable_fc  <= 1'b0;
            wr_addr_fc    <= '0;
            wr_data_fc    <= '0;
            done          <= 1'b0;

            if (clear) begin
                state_reg <= IDLE;
`ifdef W_LOAD_RANGE_CHECK_EN
                err_reg   <= 1'b0;
`endif
            end else begin
                case (state_reg)
                    IDLE: begin
                        if (start) begin
                            cnn_reg  <= (mode == 3'(MODE_CNN));
                            addr_reg <= base_addr;
                            num_reg  <= num_words;
                            cnt_reg  <= '0;
`ifdef W_LOAD_RANGE_CHECK_EN
                            err_reg  <= 1'b0;
                            if (out_of_range) begin
                                err_reg   <= 1'b1;
                                state_reg <= DONE;
                                done      <= 1'b1;
                            end else
`endif
                            if (num_words == '0) begin
                                // Empty load: complete immediately, no writes.
                                state_reg <= DONE;
                                done      <= 1'b1;
                            end else begin
                                state_reg <= LOAD;
                            end
                        end
                    end

                    LOAD: begin
                        if (stream.in_valid) begin
                            if (cnn_reg) begin
                                wr_enable_cnn <= 1'b1;
                                wr_addr_cnn   <= addr_reg;
                                wr_data_cnn   <= WORD_W'(stream.in_data);
                            end else begin
                                wr_enable_fc  <= 1'b1;
                                wr_addr_fc    <= addr_reg;
                                wr_data_fc    <= WORD_W'(stream.in_data);
                            end
                            addr_reg <= addr_reg + 1'b1;  // wraps mod 2^ADDR_W
                            cnt_reg  <= cnt_reg + 1'b1;
                            if (last_xfer) begin
                                // done lands in the same cycle as the last write.
                                state_reg <= DONE;
                                done      <= 1'b1;
                            end
                        end
                    end

                    DONE: begin
                        state_reg <= IDLE;
                    end

                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_w_mem_load_ctrl.sv
// -----------------------------------------------------------------------------
// tb_w_mem_load_ctrl
// Scoreboard bench: stimulus pushes each expected write (port, address, data,
// done flag, cycle) into a queue; a monitor on the falling edge pops and
// compares every write the DUT presents. Control outputs (done/busy/err/
// in_ready) are checked directly by the stimulus at points it can predict.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_w_mem_load_ctrl;

    typedef struct {
        bit          cnn;
        logic [11:0] addr;
        logic [31:0] data;
        bit          last;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        start = 1'b0;
    logic        clear = 1'b0;
    logic [2:0]  mode = '0;
    logic [11:0] base_addr = '0;
    logic [12:0] num_words = '0;
    logic        wr_enable_cnn, wr_enable_fc;
    logic [11:0] wr_addr_cnn, wr_addr_fc;
    logic [31:0] wr_data_cnn, wr_data_fc;
    logic        busy, done, err;

    w_mem_load_ctrl_if stream ();

    w_mem_load_ctrl dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .clear         (clear),
        .mode          (mode),
        .base_addr     (base_addr),
        .num_words     (num_words),
        .stream        (stream),
        .wr_enable_cnn (wr_enable_cnn),
        .wr_addr_cnn   (wr_addr_cnn),
        .wr_data_cnn   (wr_data_cnn),
        .wr_enable_fc  (wr_enable_fc),
        .wr_addr_fc    (wr_addr_fc),
        .wr_data_fc    (wr_data_fc),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;
    exp_t q[$];

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every presented write must match the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (wr_enable_cnn === 1'b1 || wr_enable_fc === 1'b1) begin
                if (q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("[TB] FAIL unexpected_write: cnn=%0b/%0h fc=%0b/%0h, expected no write (cycle %0d)",
                             wr_enable_cnn, wr_addr_cnn, wr_enable_fc, wr_addr_fc, cyc);
                end else begin
                    e = q.pop_front();
                    $display("[TB] write %s addr=%03h data=%08h done=%0b cycle=%0d",
                             wr_enable_cnn ? "cnn" : "fc ",
                             wr_enable_cnn ? wr_addr_cnn : wr_addr_fc,
                             wr_enable_cnn ? wr_data_cnn : wr_data_fc, done, cyc);
                    chk("write_port", {62'd0, wr_enable_cnn, wr_enable_fc}, e.cnn ? 64'd2 : 64'd1);
                    chk("write_addr", 64'(e.cnn ? wr_addr_cnn : wr_addr_fc), 64'(e.addr));
                    chk("write_data", 64'(e.cnn ? wr_data_cnn : wr_data_fc), 64'(e.data));
                    chk("unused_port_zero", e.cnn ? {20'd0, wr_addr_fc, wr_data_fc}
                                                  : {20'd0, wr_addr_cnn, wr_data_cnn}, 64'd0);
                    chk("write_done_flag", 64'(done), 64'(e.last));
                    chk("write_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic start_load(input logic [2:0] m, input logic [11:0] b, input logic [12:0] n);
        start = 1'b1; mode = m; base_addr = b; num_words = n;
        tick();
        // Scramble config to prove it was latched.
        start = 1'b0; mode = 3'd7; base_addr = 12'h5A5; num_words = 13'h1FFF;
    endtask

    task automatic xfer(input bit cnn, input logic [11:0] a, input logic [31:0] d, input bit last);
        chk("in_ready_load", 64'(stream.in_ready), 64'd1);
        stream.in_valid = 1'b1;
        stream.in_data  = d;
        q.push_back('{cnn: cnn, addr: a, data: d, last: last, cyc: cyc + 1});
        tick();
        stream.in_valid = 1'b0;
        stream.in_data  = 32'hDEAD_BEEF;
    endtask

    task automatic run_load(input logic [2:0] m, input logic [11:0] b, input int n,
                            input int gap_after, input int gap_len, input logic [15:0] tag);
        logic [11:0] a;
        start_load(m, b, 13'(n));
        for (int k = 0; k < n; k++) begin
            a = b + 12'(k);
            xfer(m == 3'd1, a, {tag, 16'(k)}, k == n - 1);
            if (k == gap_after && k < n - 1) begin
                for (int g = 0; g < gap_len; g++) begin
                    chk("in_ready_stall", 64'(stream.in_ready), 64'd1);
                    tick();
                end
            end
        end
        chk("done_pulse", 64'(done), 64'd1);
        chk("busy_in_done", 64'(busy), 64'd1);
        tick();
        chk("done_cleared", 64'(done), 64'd0);
        chk("busy_idle", 64'(busy), 64'd0);
        chk("in_ready_idle", 64'(stream.in_ready), 64'd0);
    endtask

    task automatic chk_all_zero(input string name);
        chk(name, {busy, done, err, stream.in_ready, wr_enable_cnn, wr_enable_fc,
                   2'b00, wr_addr_cnn, wr_addr_fc}, 64'd0);
        chk({name, "_data"}, {wr_data_cnn, wr_data_fc}, 64'd0);
    endtask

    initial begin
        stream.in_valid = 1'b0;
        stream.in_data  = '0;
        reset = 1'b0;
        #12;
        chk_all_zero("reset_state");
        tick();
        reset = 1'b1;
        tick();

        // CNN load, continuous valid.
        run_load(3'd1, 12'h010, 4, -1, 0, 16'h1111);

        // FC load with a two-cycle valid gap after the first transfer.
        run_load(3'd2, 12'h100, 3, 0, 2, 16'h2222);

        // Empty load: done one cycle after start, no writes.
        start_load(3'd1, 12'h055, 13'd0);
        chk("num0_done", 64'(done), 64'd1);
        chk("num0_busy", 64'(busy), 64'd1);
        chk("num0_in_ready", 64'(stream.in_ready), 64'd0);
        tick();
        chk("num0_done_end", 64'(done), 64'd0);
        chk("num0_busy_end", 64'(busy), 64'd0);

        // Range ending exactly at top of memory is always legal.
        run_load(3'd0, 12'hFFC, 4, -1, 0, 16'h3333);
        chk("err_at_top", 64'(err), 64'd0);

        // Range crossing top of memory.
`ifdef W_LOAD_RANGE_CHECK_EN
        start_load(3'd0, 12'hFFE, 13'd4);
        chk("range_err", 64'(err), 64'd1);
        chk("range_done", 64'(done), 64'd1);
        tick();
        chk("range_err_sticky", 64'(err), 64'd1);
        chk("range_busy_end", 64'(busy), 64'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        chk("range_err_cleared", 64'(err), 64'd0);
`else
        run_load(3'd0, 12'hFFE, 4, -1, 0, 16'h4444);
        chk("wrap_err_tied", 64'(err), 64'd0);
`endif

        // Clear after 2 of 5 transfers; clear beats a same-cycle handshake.
        start_load(3'd1, 12'h020, 13'd5);
        xfer(1'b1, 12'h020, 32'h5555_0000, 1'b0);
        xfer(1'b1, 12'h021, 32'h5555_0001, 1'b0);
        clear = 1'b1;
        stream.in_valid = 1'b1;
        stream.in_data  = 32'hBAD0_0002;
        tick();
        clear = 1'b0;
        stream.in_valid = 1'b0;
        chk("clear_busy", 64'(busy), 64'd0);
        chk("clear_done", 64'(done), 64'd0);
        chk("clear_in_ready", 64'(stream.in_ready), 64'd0);
        tick();
        run_load(3'd0, 12'h040, 2, -1, 0, 16'h6666);

        // Asynchronous reset in the middle of a load.
        start_load(3'd1, 12'h300, 13'd4);
        xfer(1'b1, 12'h300, 32'h7777_0000, 1'b0);
        xfer(1'b1, 12'h301, 32'h7777_0001, 1'b0);
        tick();
        stream.in_valid = 1'b1;
        stream.in_data  = 32'hBAD0_0003;
        reset = 1'b0;
        #1;
        chk_all_zero("reset_midload");
        tick();
        tick();
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("in_ready_after_reset", 64'(stream.in_ready), 64'd0);
            chk("done_after_reset", 64'(done), 64'd0);
            tick();
        end
        stream.in_valid = 1'b0;
        run_load(3'd1, 12'h3F0, 2, -1, 0, 16'h8888);

        repeat (3) tick();
        chk("scoreboard_drained", 64'(q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
